// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: Hack CPU control and register stage.
// Decodes the current instruction, holds A, D and the program counter,
// drives the ALU operands and control bits, and writes back the ALU result.
module hack_cpu_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instruction,
  input  logic        instr_valid,
  input  logic [15:0] inM,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        zx,
  output logic        nx,
  output logic        zy,
  output logic        ny,
  output logic        f,
  output logic        no,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [14:0] addressM,
  output logic [14:0] pc
);

  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic [14:0] pc_reg;
  logic [15:0] a_next;
  logic [15:0] d_next;
  logic [14:0] pc_next;
  logic        is_c;
  logic        dest_a;
  logic        dest_d;
  logic        dest_m;
  logic        jump;

  // Field decode. Bits 14:13 are unused by the ISA.
  assign is_c   = instruction[15];
  assign dest_a = instruction[5];
  assign dest_d = instruction[4];
  assign dest_m = instruction[3];

  // Jump on lt / eq / gt according to j1..j3 and the ALU flags.
  assign jump = is_c & ((instruction[2] & alu_ng) |
                        (instruction[1] & alu_zr) |
                        (instruction[0] & ~alu_ng & ~alu_zr));

  // ALU operands and controls come straight from the instruction bits;
  // for A-instructions they are simply ignored downstream.
  assign alu_x = d_reg;
  assign alu_y = instruction[12] ? inM : a_reg;
  assign {zx, nx, zy, ny, f, no} = instruction[11:6];

  // Memory side uses the current (pre-update) A as the address.
  assign outM     = alu_out;
  assign addressM = a_reg[14:0];
  assign writeM   = reset_n & instr_valid & is_c & dest_m;
  assign pc       = pc_reg;

  // Next-state selection for A, D and PC; everything holds while stalled.
  always_comb begin
    a_next  = a_reg;
    d_next  = d_reg;
    pc_next = pc_reg;
    if (instr_valid) begin
      if (!is_c) begin
        a_next = instruction;
      end else begin
        if (dest_a) a_next = alu_out;
        if (dest_d) d_next = alu_out;
      end
      if (jump) pc_next = a_reg[14:0];
      else      pc_next = pc_reg + 15'd1;
    end
  end

  // Register update with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg  <= 16'h0000;
      d_reg  <= 16'h0000;
      pc_reg <= 15'h0000;
    end else begin
      a_reg  <= a_next;
      d_reg  <= d_next;
      pc_reg <= pc_next;
    end
  end

endmodule
